// File: rtl/conv_frame_encoder_pkg.sv
// conv_frame_encoder_pkg: FSM state encoding and width helper shared by the encoder and decoder
package conv_frame_encoder_pkg;

    typedef enum logic [1:0] {IDLE, DATA, TAIL, FLUSH} enc_state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/conv_parity_unit.sv
// conv_parity_unit: one parity bit per generator over the current input window
module conv_parity_unit #(
    parameter int n = 2,
    parameter int m = 4
) (
    input  logic [m-1:0]        w,
    input  logic [n-1:0][m-1:0] gens,
    output logic [0:n-1]        parity
);

    // each output bit is the XOR of the window bits tapped by its generator
    always_comb begin
        parity = '0;
        for (int j = 0; j < n; j++) parity[j] = ^(gens[j] & w);
    end

endmodule

// File: rtl/conv_frame_encoder.sv
// conv_frame_encoder: framed convolutional encoder with zero tail and one-deep output register
module conv_frame_encoder
    import conv_frame_encoder_pkg::*;
#(
    parameter int n = 2,
    parameter int k = 1,
    parameter int m = 4,
    parameter int L = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [clog2(n)-1:0]   gen_address,
    input  logic [m-1:0]          gen_data,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [0:k-1]          in_bits,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [0:n-1]          encoded,
    output logic                  frame_start,
    output logic                  busy
);

    localparam int T  = (m - k) / k;
    localparam int D  = L - T;
    localparam int CW = clog2(L + 1);
    localparam logic [CW-1:0] D_LAST = CW'(D - 1);
    localparam logic [CW-1:0] L_LAST = CW'(L - 1);

    enc_state_t          st;
    logic [m-k-1:0]      shift;
    logic [CW-1:0]       cnt;
    logic [n-1:0][m-1:0] gens;
    logic                room, accept, tail_go, step;
    logic [0:k-1]        data_bits;
    logic [m-1:0]        w;
    logic [0:n-1]        parity;

    assign room      = !out_valid || out_ready;
    assign in_ready  = (st == DATA) && room;
    assign accept    = in_ready && in_valid;
    assign tail_go   = (st == TAIL) && room;
    assign step      = accept || tail_go;
    assign data_bits = (st == TAIL) ? '0 : in_bits;
    assign w         = {data_bits, shift};
    assign busy      = st != IDLE;

    conv_parity_unit #(.n(n), .m(m)) u_parity (
        .w      (w),
        .gens   (gens),
        .parity (parity)
    );

    // frame sequencing, generator writes, shift state and the output register slice
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st          <= IDLE;
            shift       <= '0;
            cnt         <= '0;
            gens        <= '0;
            out_valid   <= 1'b0;
            encoded     <= '0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            if (step) begin
                out_valid <= 1'b1;
                encoded   <= parity;
                shift     <= w[m-1:k];
                cnt       <= cnt + 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            case (st)
                IDLE: begin
                    if (load) begin
                        if (int'(gen_address) < n) gens[gen_address] <= gen_data;
                    end else if (start) begin
                        shift       <= '0;
                        cnt         <= '0;
                        frame_start <= 1'b1;
                        st          <= DATA;
                    end
                end
                DATA:    if (accept && cnt == D_LAST) st <= TAIL;
                TAIL:    if (tail_go && cnt == L_LAST) st <= FLUSH;
                FLUSH:   if (out_valid && out_ready) st <= IDLE;
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/conv_frame_encoder.md
CONV_FRAME_ENCODER -- requirements
Module: conv_frame_encoder

Interface
REQ-001 SHALL have parameter n, default 2: output bits per trellis symbol.
REQ-002 SHALL have parameter k, default 1: input bits per trellis symbol.
REQ-003 SHALL have parameter m, default 4: constraint window in bits (k new bits plus m-k state bits).
REQ-004 SHALL have parameter L, default 7: symbols per frame, tail included. Constraint: (m-k) divisible by k, and L > (m-k)/k.
REQ-005 SHALL have derived constant T = (m-k)/k (tail symbols) and D = L-T (data symbols per frame).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-low reset of the whole block.
REQ-008 SHALL have port load, input, 1 bit: write one generator polynomial this cycle.
REQ-009 SHALL have port gen_address, input, clog2(n) bits (minimum 1 bit): index of the generator to write.
REQ-010 SHALL have port gen_data, input, m bits: generator taps; MSB is the tap on the newest input bit.
REQ-011 SHALL have port start, input, 1 bit: begin a new frame.
REQ-012 SHALL have port in_valid, input, 1 bit: in_bits is valid.
REQ-013 SHALL have port in_ready, output, 1 bit: block accepts in_bits this cycle.
REQ-014 SHALL have port in_bits, input, [0:k-1]: data bits for one symbol.
REQ-015 SHALL have port out_valid, output, 1 bit: encoded holds a valid symbol; drives the decoder enable.
REQ-016 SHALL have port out_ready, input, 1 bit: downstream consumes the symbol this cycle.
REQ-017 SHALL have port encoded, output, [0:n-1]: encoded symbol; bit j comes from generator j.
REQ-018 SHALL have port frame_start, output, 1 bit: one-cycle pulse; drives the decoder restart.
REQ-019 SHALL have port busy, output, 1 bit: a frame is in progress.

Function
REQ-020 FSM states SHALL be IDLE, DATA, TAIL and FLUSH; reset enters IDLE.
REQ-021 IDLE: start=1 with load=0 SHALL clear shift state to 0, clear the symbol counter, pulse frame_start for one cycle, and go to DATA.
REQ-022 A symbol SHALL be produced only when the output register is empty or out_ready=1 in the same cycle (register slice, one symbol deep).
REQ-023 DATA: in_ready = 1 when REQ-022 holds; on in_valid and in_ready, window w = {in_bits, state}.
REQ-024 For each symbol, encoded[j] SHALL equal the XOR reduction of (gen[j] AND w), and state SHALL become the top m-k bits of w.
REQ-025 The symbol SHALL appear on encoded with out_valid=1 in the cycle after acceptance (latency 1).
REQ-026 After D accepted symbols, the FSM SHALL go to TAIL.
REQ-027 TAIL: in_ready = 0; the block SHALL internally inject all-zero in_bits whenever REQ-022 holds, for exactly T symbols, which returns state to 0.
REQ-028 After the T-th tail symbol is registered, the FSM SHALL go to FLUSH.
REQ-029 FLUSH: the FSM SHALL return to IDLE once the last symbol is consumed (out_valid=1 and out_ready=1).
REQ-030 out_valid and encoded SHALL hold stable while out_valid=1 and out_ready=0.
REQ-031 Exactly L symbols SHALL be emitted per frame.
REQ-032 busy = 1 in DATA, TAIL and FLUSH.
REQ-033 start SHALL be ignored unless in IDLE; start during a frame has no effect.
REQ-034 load SHALL be honoured only in IDLE; load in any other state is ignored.
REQ-035 If start and load are both asserted in IDLE, load SHALL win and start SHALL be ignored.
REQ-036 The symbol counter SHALL be clog2(L+1) bits wide and SHALL never wrap within a frame.

Reset
REQ-037 reset=0 SHALL asynchronously force: state IDLE; shift state 0; counter 0; all generators 0; out_valid=0; encoded=0; in_ready=0; frame_start=0; busy=0.
REQ-038 Reset asserted mid-frame SHALL abort the frame with no further symbols.
REQ-039 Generators SHALL be reloaded after any reset.

Structure
REQ-040 A shared package SHALL hold the FSM state encoding and the clog2 helper, also used by the decoder.
REQ-041 One sub-module, conv_parity_unit, SHALL compute n parity bits from w and the generators combinationally.

Verification
REQ-042 n=2, k=1, m=4, L=7, gen0=1011, gen1=1111, input 1,0,1,1, out_ready held 1 -> encoded sequence 11,01,00,01,10,00,11; frame_start one pulse; busy falls after the 7th symbol.
REQ-043 Same stimulus with out_ready=0 on cycles 2-4 -> identical sequence; encoded stable while stalled; in_ready=0 while the register is full.
REQ-044 start pulsed during DATA -> ignored; the frame completes with 7 symbols; no second frame_start.
REQ-045 reset driven low after the 3rd symbol -> out_valid=0 immediately, state IDLE; a new frame after reloading generators reproduces REQ-042.
REQ-046 load and start in the same IDLE cycle -> generator written, no frame_start, busy stays 0.
REQ-047 Encoder output fed to the decoder (enable=out_valid, restart=frame_start) -> decoded=1011000, error=0; flipping one encoded bit gives error=1 with the same decoded value.
